// File: rtl/spare_sram_access_ctrl.sv
// Sequencer for the 25-bank spare SRAM array: single-byte read/write requests in, one response out.
// Latency from accept edge: read 4, write 3 (6 with SPARE_WVERIFY_EN read-back), bank-range error 1.
// One request in flight; REQ_READY only in IDLE, and a response is held until RSP_READY is sampled high.
module spare_sram_access_ctrl #(
    parameter int NUM_BANKS = 25,
    parameter int BANK_AW   = 5,
    parameter int ROW_AW    = 7,
    parameter int DW        = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic                      REQ_WRITE,
    input  logic [BANK_AW+ROW_AW-1:0] REQ_ADDR,
    input  logic [DW-1:0]             REQ_WDATA,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [DW-1:0]             RSP_RDATA,
    output logic                      RSP_ERR,
    output logic [ROW_AW-1:0]         MEM_ADDR,
    output logic                      MEM_CE,
    output logic                      MEM_WEB,
    output logic [NUM_BANKS-1:0]      MEM_OEB,
    output logic [NUM_BANKS-1:0]      MEM_CSB,
    output logic [DW-1:0]             MEM_IDATA,
    input  logic [DW-1:0]             MEM_ODATA
);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, CAPT, RESP
`ifdef SPARE_WVERIFY_EN
        , VSETUP, VSTROBE, VCAPT
`endif
    } state_t;

    state_t state, next_state;

    logic [BANK_AW-1:0] req_bank;
    logic [ROW_AW-1:0]  req_row;
    logic               req_bank_bad;
    logic               lat_write;
    logic [BANK_AW-1:0] lat_bank;
`ifdef SPARE_WVERIFY_EN
    logic [DW-1:0]      lat_wdata;
`endif

    logic [ROW_AW-1:0]    nx_mem_addr;
    logic                 nx_mem_ce;
    logic                 nx_mem_web;
    logic [NUM_BANKS-1:0] nx_mem_oeb;
    logic [NUM_BANKS-1:0] nx_mem_csb;
    logic [DW-1:0]        nx_mem_idata;
    logic                 nx_rsp_valid;
    logic [DW-1:0]        nx_rsp_rdata;
    logic                 nx_rsp_err;

    function automatic logic [NUM_BANKS-1:0] bank_sel(input logic [BANK_AW-1:0] b);
        bank_sel = {{(NUM_BANKS-1){1'b0}}, 1'b1} << b;
    endfunction

    assign req_bank     = REQ_ADDR[BANK_AW+ROW_AW-1:ROW_AW];
    assign req_row      = REQ_ADDR[ROW_AW-1:0];
    assign req_bank_bad = (32'(req_bank) >= NUM_BANKS);
    assign REQ_READY    = (state == IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            lat_write <= 1'b0;
            lat_bank  <= '0;
`ifdef SPARE_WVERIFY_EN
            lat_wdata <= '0;
`endif
        end else begin
            state <= next_state;
            if (state == IDLE && REQ_VALID) begin
                lat_write <= REQ_WRITE;
                lat_bank  <= req_bank;
`ifdef SPARE_WVERIFY_EN
                lat_wdata <= REQ_WDATA;
`endif
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (REQ_VALID) next_state = req_bank_bad ? RESP : SETUP;
            SETUP:   next_state = STROBE;
`ifdef SPARE_WVERIFY_EN
            STROBE:  next_state = lat_write ? VSETUP : CAPT;
            VSETUP:  next_state = VSTROBE;
            VSTROBE: next_state = VCAPT;
            VCAPT:   next_state = RESP;
`else
            STROBE:  next_state = lat_write ? RESP : CAPT;
`endif
            CAPT:    next_state = RESP;
            RESP:    if (RSP_READY) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs are loaded with the values belonging to the state being entered.
    always_comb begin
        nx_mem_addr  = MEM_ADDR;
        nx_mem_ce    = MEM_CE;
        nx_mem_web   = MEM_WEB;
        nx_mem_oeb   = MEM_OEB;
        nx_mem_csb   = MEM_CSB;
        nx_mem_idata = MEM_IDATA;
        nx_rsp_valid = RSP_VALID;
        nx_rsp_rdata = RSP_RDATA;
        nx_rsp_err   = RSP_ERR;
        case (next_state)
            SETUP: begin
                nx_mem_addr  = req_row;
                nx_mem_csb   = ~bank_sel(req_bank);
                nx_mem_web   = ~REQ_WRITE;
                nx_mem_idata = REQ_WDATA;
                nx_mem_oeb   = '1;
                nx_mem_ce    = 1'b0;
            end
            STROBE: nx_mem_ce = 1'b1;
            CAPT: begin
                nx_mem_ce  = 1'b0;
                nx_mem_oeb = ~bank_sel(lat_bank);
            end
`ifdef SPARE_WVERIFY_EN
            VSETUP: begin
                nx_mem_ce  = 1'b0;
                nx_mem_web = 1'b1;
            end
            VSTROBE: nx_mem_ce = 1'b1;
            VCAPT: begin
                nx_mem_ce  = 1'b0;
                nx_mem_oeb = ~bank_sel(lat_bank);
            end
`endif
            RESP: begin
                if (state != RESP) begin
                    nx_mem_csb   = '1;
                    nx_mem_oeb   = '1;
                    nx_mem_web   = 1'b1;
                    nx_mem_ce    = 1'b0;
                    nx_rsp_valid = 1'b1;
                    nx_rsp_rdata = '0;
                    nx_rsp_err   = 1'b0;
                    case (state)
                        IDLE:  nx_rsp_err   = 1'b1;
                        CAPT:  nx_rsp_rdata = MEM_ODATA;
`ifdef SPARE_WVERIFY_EN
                        VCAPT: begin
                            nx_rsp_rdata = MEM_ODATA;
                            nx_rsp_err   = (MEM_ODATA != lat_wdata);
                        end
`endif
                        default: ;
                    endcase
                end
            end
            IDLE: nx_rsp_valid = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            MEM_ADDR  <= '0;
            MEM_CE    <= 1'b0;
            MEM_WEB   <= 1'b1;
            MEM_OEB   <= '1;
            MEM_CSB   <= '1;
            MEM_IDATA <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            MEM_ADDR  <= nx_mem_addr;
            MEM_CE    <= nx_mem_ce;
            MEM_WEB   <= nx_mem_web;
            MEM_OEB   <= nx_mem_oeb;
            MEM_CSB   <= nx_mem_csb;
            MEM_IDATA <= nx_mem_idata;
            RSP_VALID <= nx_rsp_valid;
            RSP_RDATA <= nx_rsp_rdata;
            RSP_ERR   <= nx_rsp_err;
        end
    end

endmodule

// File: tb/tb_spare_sram_access_ctrl.sv
// Bench for spare_sram_access_ctrl: behavioural 25-bank SRAM model plus a response scoreboard.
module tb_spare_sram_access_ctrl;

    localparam int NB = 25;
`ifdef SPARE_WVERIFY_EN
    localparam int WR_LAT = 6;
    localparam int WR_CE  = 2;
`else
    localparam int WR_LAT = 3;
    localparam int WR_CE  = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WRITE = 1'b0;
    logic [11:0]   REQ_ADDR = '0;
    logic [7:0]    REQ_WDATA = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b1;
    logic [7:0]    RSP_RDATA;
    logic          RSP_ERR;
    logic [6:0]    MEM_ADDR;
    logic          MEM_CE;
    logic          MEM_WEB;
    logic [NB-1:0] MEM_OEB;
    logic [NB-1:0] MEM_CSB;
    logic [7:0]    MEM_IDATA;
    logic [7:0]    MEM_ODATA;

    spare_sram_access_ctrl dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE), .MEM_WEB(MEM_WEB), .MEM_OEB(MEM_OEB),
        .MEM_CSB(MEM_CSB), .MEM_IDATA(MEM_IDATA), .MEM_ODATA(MEM_ODATA)
    );

    always #5 CLK = ~CLK;

    // SRAM array model: access on CE rise, read byte driven only while some OEB is low.
    logic [7:0] mem [0:NB-1][0:127];
    logic [7:0] rd_q = 8'h00;
    logic       stuck0 = 1'b0;

    initial begin
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < 128; r++)
                mem[b][r] = 8'h00;
    end

    always @(posedge MEM_CE) begin
        for (int b = 0; b < NB; b++) begin
            if (!MEM_CSB[b]) begin
                if (!MEM_WEB) mem[b][MEM_ADDR] = MEM_IDATA;
                else          rd_q = (stuck0 && b == 0) ? 8'h00 : mem[b][MEM_ADDR];
            end
        end
    end

    assign MEM_ODATA = (&MEM_OEB) ? 8'h00 : rd_q;

    typedef struct { logic [7:0] rd; logic err; } exp_t;
    exp_t exp_q[$];
    exp_t ex;

    int checks = 0;
    int failures = 0;

    logic [NB-1:0] snap_csb   [0:20];
    logic [NB-1:0] snap_oeb   [0:20];
    logic          snap_ce    [0:20];
    logic          snap_web   [0:20];
    logic [6:0]    snap_addr  [0:20];
    logic [7:0]    snap_idata [0:20];
    int            ce_cnt;
    int            inv_bad;

    // Drives one request and records per-cycle array activity up to the response.
    task automatic do_txn(input logic w, input logic [11:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd, output logic er);
        lat = -1; rd = 8'h00; er = 1'b0; ce_cnt = 0; inv_bad = 0;
        @(posedge CLK); #1;
        REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = d;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            snap_csb[c] = MEM_CSB; snap_oeb[c] = MEM_OEB; snap_ce[c] = MEM_CE;
            snap_web[c] = MEM_WEB; snap_addr[c] = MEM_ADDR; snap_idata[c] = MEM_IDATA;
            if (MEM_CE) ce_cnt++;
            if ($countones(~MEM_CSB) > 1 || ((~MEM_OEB) & MEM_CSB) != '0) inv_bad++;
            if (RSP_VALID) begin
                lat = c; rd = RSP_RDATA; er = RSP_ERR;
                break;
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (MEM_CSB !== 25'h1FFFFFF) begin failures++; $display("FAIL reset_csb got=%h exp=1ffffff", MEM_CSB); end
        checks++; if (MEM_OEB !== 25'h1FFFFFF) begin failures++; $display("FAIL reset_oeb got=%h exp=1ffffff", MEM_OEB); end
        checks++; if (MEM_CE !== 1'b0 || MEM_WEB !== 1'b1) begin failures++; $display("FAIL reset_ce_web got=%b%b exp=01", MEM_CE, MEM_WEB); end
        checks++; if (RSP_VALID !== 1'b0 || RSP_ERR !== 1'b0 || RSP_RDATA !== 8'h00) begin failures++; $display("FAIL reset_rsp got=%b%b%h exp=0000", RSP_VALID, RSP_ERR, RSP_RDATA); end
        checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", REQ_READY); end
        checks++; if (MEM_ADDR !== 7'h00 || MEM_IDATA !== 8'h00) begin failures++; $display("FAIL reset_addr_idata got=%h/%h exp=0/0", MEM_ADDR, MEM_IDATA); end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_write();
        int lat; logic [7:0] rd; logic er;
`ifdef SPARE_WVERIFY_EN
        exp_q.push_back('{rd: 8'hA5, err: 1'b0});
`else
        exp_q.push_back('{rd: 8'h00, err: 1'b0});
`endif
        do_txn(1'b1, 12'h283, 8'hA5, lat, rd, er);
        ex = exp_q.pop_front();
        checks++; if (snap_csb[1] !== ~25'h20) begin failures++; $display("FAIL wr_csb got=%h exp=%h", snap_csb[1], ~25'h20); end
        checks++; if (snap_web[1] !== 1'b0 || snap_ce[1] !== 1'b0) begin failures++; $display("FAIL wr_web_ce got=%b%b exp=00", snap_web[1], snap_ce[1]); end
        checks++; if (snap_addr[1] !== 7'd3 || snap_idata[1] !== 8'hA5) begin failures++; $display("FAIL wr_addr_data got=%h/%h exp=3/a5", snap_addr[1], snap_idata[1]); end
        checks++; if (snap_ce[2] !== 1'b1) begin failures++; $display("FAIL wr_strobe got=%b exp=1", snap_ce[2]); end
        checks++; if (lat !== WR_LAT) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WR_LAT); end
        checks++; if (rd !== ex.rd || er !== ex.err) begin failures++; $display("FAIL wr_rsp got=%h/%b exp=%h/%b", rd, er, ex.rd, ex.err); end
        checks++; if (ce_cnt !== WR_CE) begin failures++; $display("FAIL wr_ce_cycles got=%0d exp=%0d", ce_cnt, WR_CE); end
    endtask

    task automatic test_read();
        int lat; logic [7:0] rd; logic er;
        exp_q.push_back('{rd: 8'hA5, err: 1'b0});
        do_txn(1'b0, 12'h283, 8'h00, lat, rd, er);
        ex = exp_q.pop_front();
        checks++; if (snap_web[1] !== 1'b1 || snap_csb[1] !== ~25'h20) begin failures++; $display("FAIL rd_setup got=%b/%h exp=1/%h", snap_web[1], snap_csb[1], ~25'h20); end
        checks++; if (snap_oeb[3] !== ~25'h20 || snap_ce[3] !== 1'b0) begin failures++; $display("FAIL rd_capt_oeb got=%h/%b exp=%h/0", snap_oeb[3], snap_ce[3], ~25'h20); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL rd_latency got=%0d exp=4", lat); end
        checks++; if (rd !== ex.rd || er !== ex.err) begin failures++; $display("FAIL rd_rsp got=%h/%b exp=%h/%b", rd, er, ex.rd, ex.err); end
        checks++; if (ce_cnt !== 1 || inv_bad !== 0) begin failures++; $display("FAIL rd_ce_inv got=%0d/%0d exp=1/0", ce_cnt, inv_bad); end
    endtask

    task automatic test_bank_err();
        int lat; logic [7:0] rd; logic er;
        logic [11:0] bad_addr [0:1];
        bad_addr[0] = 12'hC80;
        bad_addr[1] = 12'hFFF;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{rd: 8'h00, err: 1'b1});
            do_txn(i[0], bad_addr[i], 8'h5A, lat, rd, er);
            ex = exp_q.pop_front();
            checks++; if (lat !== 1) begin failures++; $display("FAIL err_latency[%0d] got=%0d exp=1", i, lat); end
            checks++; if (rd !== ex.rd || er !== ex.err) begin failures++; $display("FAIL err_rsp[%0d] got=%h/%b exp=%h/%b", i, rd, er, ex.rd, ex.err); end
            checks++; if (ce_cnt !== 0 || snap_csb[1] !== 25'h1FFFFFF) begin failures++; $display("FAIL err_no_access[%0d] got=%0d/%h exp=0/1ffffff", i, ce_cnt, snap_csb[1]); end
        end
    endtask

    task automatic test_backpressure();
        int seen; int lat; logic [7:0] rd; logic er;
        seen = 0;
        exp_q.push_back('{rd: 8'hA5, err: 1'b0});
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 12'h283;
        @(posedge CLK); #1;
        REQ_WRITE = 1'b1; REQ_ADDR = 12'h001; REQ_WDATA = 8'hFF;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge CLK);
            if (RSP_VALID) seen = 1;
        end
        checks++; if (seen !== 1) begin failures++; $display("FAIL bp_rsp_timeout got=%0d exp=1", seen); end
        ex = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge CLK);
            checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== ex.rd || RSP_ERR !== ex.err) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/%h/%b", k, RSP_VALID, RSP_RDATA, RSP_ERR, ex.rd, ex.err); end
            checks++; if (REQ_READY !== 1'b0 || MEM_CE !== 1'b0 || MEM_CSB !== 25'h1FFFFFF) begin failures++; $display("FAIL bp_idle_array[%0d] got=%b/%b/%h exp=0/0/1ffffff", k, REQ_READY, MEM_CE, MEM_CSB); end
        end
        @(posedge CLK); #1;
        RSP_READY = 1'b1; REQ_VALID = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin failures++; $display("FAIL bp_release got=%b/%b exp=1/0", REQ_READY, RSP_VALID); end
        exp_q.push_back('{rd: 8'h00, err: 1'b0});
        do_txn(1'b0, 12'h001, 8'h00, lat, rd, er);
        ex = exp_q.pop_front();
        checks++; if (rd !== ex.rd || er !== ex.err) begin failures++; $display("FAIL bp_ignored_write got=%h/%b exp=%h/%b", rd, er, ex.rd, ex.err); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] rd; logic er;
        logic [11:0] a [0:4];
        logic [7:0]  d [0:4];
        for (int i = 0; i < 4; i++) begin
            a[i] = {5'((i * 7 + 3) % 25), 7'(i * 9 + 1)};
            d[i] = 8'($urandom_range(1, 255));
        end
        a[4] = {5'd24, 7'h7F};
        d[4] = 8'h6E;
        for (int i = 0; i < 5; i++) begin
`ifdef SPARE_WVERIFY_EN
            exp_q.push_back('{rd: d[i], err: 1'b0});
`else
            exp_q.push_back('{rd: 8'h00, err: 1'b0});
`endif
            do_txn(1'b1, a[i], d[i], lat, rd, er);
            ex = exp_q.pop_front();
            checks++; if (rd !== ex.rd || er !== ex.err || lat !== WR_LAT) begin failures++; $display("FAIL b2b_wr[%0d] got=%h/%b/%0d exp=%h/%b/%0d", i, rd, er, lat, ex.rd, ex.err, WR_LAT); end
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{rd: d[i], err: 1'b0});
            do_txn(1'b0, a[i], 8'h00, lat, rd, er);
            ex = exp_q.pop_front();
            checks++; if (rd !== ex.rd || er !== ex.err || lat !== 4) begin failures++; $display("FAIL b2b_rd[%0d] got=%h/%b/%0d exp=%h/%b/4", i, rd, er, lat, ex.rd, ex.err); end
            checks++; if (inv_bad !== 0 || snap_csb[1] !== ~(25'h1 << a[i][11:7])) begin failures++; $display("FAIL b2b_csb[%0d] got=%h/%0d exp=%h/0", i, snap_csb[1], inv_bad, ~(25'h1 << a[i][11:7])); end
        end
    endtask

    task automatic test_throughput();
        int idle_cnt; int rsp_cnt; int rsp_bad;
        idle_cnt = 0; rsp_cnt = 0; rsp_bad = 0;
        REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 12'h283;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (REQ_READY) idle_cnt++;
            if (RSP_VALID) begin
                rsp_cnt++;
                if (RSP_RDATA !== 8'hA5 || RSP_ERR !== 1'b0) rsp_bad++;
            end
        end
        REQ_VALID = 1'b0;
        @(posedge CLK); #1;
        checks++; if (idle_cnt !== 4) begin failures++; $display("FAIL tput_accepts got=%0d exp=4", idle_cnt); end
        checks++; if (rsp_cnt !== 4 || rsp_bad !== 0) begin failures++; $display("FAIL tput_rsps got=%0d/%0d exp=4/0", rsp_cnt, rsp_bad); end
    endtask

    task automatic test_stuck_verify();
        int lat; logic [7:0] rd; logic er;
        stuck0 = 1'b1;
`ifdef SPARE_WVERIFY_EN
        exp_q.push_back('{rd: 8'h00, err: 1'b1});
`else
        exp_q.push_back('{rd: 8'h00, err: 1'b0});
`endif
        do_txn(1'b1, 12'h005, 8'h3C, lat, rd, er);
        ex = exp_q.pop_front();
        stuck0 = 1'b0;
        checks++; if (rd !== ex.rd || er !== ex.err || lat !== WR_LAT) begin failures++; $display("FAIL stuck_wr got=%h/%b/%0d exp=%h/%b/%0d", rd, er, lat, ex.rd, ex.err, WR_LAT); end
    endtask

    task automatic test_reset_midflight();
        int bad;
        bad = 0;
        @(posedge CLK); #1;
        REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 12'h0A1; REQ_WDATA = 8'h77;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (MEM_CE !== 1'b1) begin failures++; $display("FAIL rst_mid_in_strobe got=%b exp=1", MEM_CE); end
        RST = 1'b1;
        #1;
        checks++; if (MEM_CE !== 1'b0 || MEM_WEB !== 1'b1 || MEM_CSB !== 25'h1FFFFFF || MEM_OEB !== 25'h1FFFFFF) begin failures++; $display("FAIL rst_mid_mem got=%b/%b/%h/%h exp=0/1/1ffffff/1ffffff", MEM_CE, MEM_WEB, MEM_CSB, MEM_OEB); end
        checks++; if (MEM_ADDR !== 7'h00 || MEM_IDATA !== 8'h00 || RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin failures++; $display("FAIL rst_mid_regs got=%h/%h/%b/%b exp=0/0/0/1", MEM_ADDR, MEM_IDATA, RSP_VALID, REQ_READY); end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b0 || MEM_CE !== 1'b0 || REQ_READY !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rst_mid_no_rsp got=%0d exp=0", bad); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bank_err();
        test_backpressure();
        test_back_to_back();
        test_throughput();
        test_stuck_verify();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
